// File: rtl/matrix_packer_pkg.sv
// Purpose: shared sizing, state encodings and slot geometry for the packed-matrix interface.
// Latency: n/a (declarations only).
// Backpressure: n/a; readers use slot_offset() to locate element k inside a matrix word.
package matrix_packer_pkg;

    localparam int ELEM_W_DEF  = 4;
    localparam int N_ELEMS_DEF = 4;
    localparam int MAT_W_DEF   = N_ELEMS_DEF * ELEM_W_DEF;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    // Low bit position of slot k in a matrix word.
    function automatic int slot_offset(input int k, input int elem_w);
        return k * elem_w;
    endfunction

endpackage

// File: rtl/matrix_packer.sv
// Purpose: packs a serial stream of ELEM_W-bit elements into one N_ELEMS*ELEM_W matrix word.
// Latency: last element accepted at edge t -> matrix_valid and final matrix_out from t+1.
// Backpressure: elem_ready drops while a complete matrix is held; released by matrix_ready.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear             synchronous flush back to an empty matrix (drops same-cycle element)
//   elem_in/_valid    element stream in; elem_ready is registered, a function of state only
//   matrix_out/_valid registered packed matrix; matrix_ready consumes it
//   fill_count        number of elements held (0..N_ELEMS)
module matrix_packer
    import matrix_packer_pkg::*;
#(
    parameter int ELEM_W  = ELEM_W_DEF,
    parameter int N_ELEMS = N_ELEMS_DEF,
    localparam int MAT_W  = N_ELEMS * ELEM_W,
    localparam int CNT_W  = $clog2(N_ELEMS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ELEM_W-1:0] elem_in,
    input  logic              elem_valid,
    output logic              elem_ready,
    output logic [MAT_W-1:0]  matrix_out,
    output logic              matrix_valid,
    input  logic              matrix_ready,
    output logic [CNT_W-1:0]  fill_count
);

    state_t             state;
    logic [N_ELEMS-1:0] slot_we;
    logic               accept;

    assign accept = (state == ST_FILL) && elem_valid;

    // One-hot slot write enable decoded from the fill counter.
    always_comb begin
        slot_we = '0;
        for (int k = 0; k < N_ELEMS; k++) begin
            slot_we[k] = accept && (fill_count == CNT_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            // Both discard any partial or held matrix; reset wins simply by sharing the path.
            state        <= ST_FILL;
            matrix_out   <= '0;
            fill_count   <= '0;
            matrix_valid <= 1'b0;
            elem_ready   <= 1'b1;
        end else begin
            case (state)
                ST_FILL: begin
                    for (int k = 0; k < N_ELEMS; k++) begin
                        if (slot_we[k]) begin
                            matrix_out[slot_offset(k, ELEM_W) +: ELEM_W] <= elem_in;
                        end
                    end
                    if (accept) begin
                        fill_count <= fill_count + CNT_W'(1);
                        if (fill_count == CNT_W'(N_ELEMS - 1)) begin
                            state        <= ST_FULL;
                            matrix_valid <= 1'b1;
                            elem_ready   <= 1'b0;
                        end
                    end
                end
                ST_FULL: begin
                    // Matrix and count are frozen; incoming elements are ignored, no bypass.
                    if (matrix_ready) begin
                        state        <= ST_FILL;
                        matrix_out   <= '0;
                        fill_count   <= '0;
                        matrix_valid <= 1'b0;
                        elem_ready   <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_packer.sv
// Purpose: directed self-checking bench for matrix_packer with default parameters.
// Latency: inputs driven after the falling edge, outputs sampled at the following falling edge.
// Backpressure: exercises FULL hold, drain, clear, reset-in-FULL and stray matrix_ready.
module tb_matrix_packer;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [3:0]  elem_in;
    logic        elem_valid;
    logic        elem_ready;
    logic [15:0] matrix_out;
    logic        matrix_valid;
    logic        matrix_ready;
    logic [2:0]  fill_count;

    int compared;
    int mismatched;

    matrix_packer dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .elem_in      (elem_in),
        .elem_valid   (elem_valid),
        .elem_ready   (elem_ready),
        .matrix_out   (matrix_out),
        .matrix_valid (matrix_valid),
        .matrix_ready (matrix_ready),
        .fill_count   (fill_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] out, input logic [2:0] cnt,
                             input logic vld, input logic rdy);
        check({tag, ".out"}, 32'(matrix_out), 32'(out));
        check({tag, ".cnt"}, 32'(fill_count), 32'(cnt));
        check({tag, ".vld"}, 32'(matrix_valid), 32'(vld));
        check({tag, ".rdy"}, 32'(elem_ready), 32'(rdy));
    endtask

    task automatic send(input logic [3:0] d);
        elem_in    = d;
        elem_valid = 1'b1;
        step();
        elem_valid = 1'b0;
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        clear        = 1'b0;
        elem_in      = 4'h0;
        elem_valid   = 1'b0;
        matrix_ready = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b1);

        // 1: back-to-back fill
        elem_valid = 1'b1;
        elem_in = 4'h1; step(); check_all("t1.e1", 16'h0001, 3'd1, 1'b0, 1'b1);
        elem_in = 4'h2; step(); check_all("t1.e2", 16'h0021, 3'd2, 1'b0, 1'b1);
        elem_in = 4'h3; step(); check_all("t1.e3", 16'h0321, 3'd3, 1'b0, 1'b1);
        elem_in = 4'h4; step(); check_all("t1.full", 16'h4321, 3'd4, 1'b1, 1'b0);

        // 2: hold in FULL with elements pushing, then drain
        elem_in = 4'hF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2.hold.out", 32'(matrix_out), 32'h4321);
        end
        check_all("t2.hold", 16'h4321, 3'd4, 1'b1, 1'b0);
        elem_valid   = 1'b0;
        matrix_ready = 1'b1;
        step();
        matrix_ready = 1'b0;
        check_all("t2.drain", 16'h0000, 3'd0, 1'b0, 1'b1);

        // 3: gapped stream 1,0,0,1,1,0,1 ; idle cycles carry junk data
        send(4'hA);
        elem_in = 4'hE; step();
        elem_in = 4'h5; step();
        check_all("t3.gap", 16'h000A, 3'd1, 1'b0, 1'b1);
        send(4'hB);
        send(4'hC);
        elem_in = 4'h7; step();
        check_all("t3.gap2", 16'h0CBA, 3'd3, 1'b0, 1'b1);
        send(4'hD);
        check_all("t3.full", 16'hDCBA, 3'd4, 1'b1, 1'b0);
        matrix_ready = 1'b1;
        step();
        matrix_ready = 1'b0;
        check_all("t3.drain", 16'h0000, 3'd0, 1'b0, 1'b1);

        // 4: clear mid-fill drops the concurrent element
        send(4'h5);
        send(4'h6);
        check_all("t4.part", 16'h0065, 3'd2, 1'b0, 1'b1);
        clear = 1'b1;
        send(4'h7);
        clear = 1'b0;
        check_all("t4.clear", 16'h0000, 3'd0, 1'b0, 1'b1);
        send(4'h8);
        send(4'h9);
        send(4'hA);
        send(4'hB);
        check_all("t4.full", 16'hBA98, 3'd4, 1'b1, 1'b0);

        // 5: reset in FULL together with matrix_ready
        reset        = 1'b1;
        matrix_ready = 1'b1;
        step();
        reset        = 1'b0;
        matrix_ready = 1'b0;
        check_all("t5.reset", 16'h0000, 3'd0, 1'b0, 1'b1);

        // 6: matrix_ready during FILL has no effect
        send(4'h3);
        check_all("t6.pre", 16'h0003, 3'd1, 1'b0, 1'b1);
        matrix_ready = 1'b1;
        step();
        step();
        matrix_ready = 1'b0;
        check_all("t6.post", 16'h0003, 3'd1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
